// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: shared timing constants for the raster generator.
//   - default 800x600 @ 72 Hz timing (50 MHz pixel clock, 1040 x 666 total)
//   - axis_total(): derives H_TOTAL / V_TOTAL from the four per-axis intervals
//   - counter widths and the largest totals those widths can hold
package vga_pkg;

    localparam int unsigned H_VISIBLE_DEF = 800;
    localparam int unsigned H_FRONT_DEF   = 56;
    localparam int unsigned H_SYNC_DEF    = 120;
    localparam int unsigned H_BACK_DEF    = 64;

    localparam int unsigned V_VISIBLE_DEF = 600;
    localparam int unsigned V_FRONT_DEF   = 37;
    localparam int unsigned V_SYNC_DEF    = 6;
    localparam int unsigned V_BACK_DEF    = 23;

    localparam bit SYNC_POL_DEF = 1'b1;

    localparam int unsigned HCW = 11;
    localparam int unsigned VCW = 10;
    localparam int unsigned H_TOTAL_MAX = 1 << HCW;
    localparam int unsigned V_TOTAL_MAX = 1 << VCW;

    function automatic int unsigned axis_total(
        int unsigned visible, int unsigned front, int unsigned sync, int unsigned back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bus.
//   en                       pixel enable, driven by the consumer side
//   hcount, vcount           current raster position
//   hsync, vsync, blank      decoded video timing
//   line_start, frame_start  strobes at hcount==0 / (hcount,vcount)==(0,0)
// modport master: the timing generator; modport slave: pixel-producing blocks.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic           en;
    logic [HCW-1:0] hcount;
    logic [VCW-1:0] vcount;
    logic           hsync;
    logic           vsync;
    logic           blank;
    logic           line_start;
    logic           frame_start;

    modport master (
        input  en,
        output hcount, vcount, hsync, vsync, blank, line_start, frame_start
    );

    modport slave (
        output en,
        input  hcount, vcount, hsync, vsync, blank, line_start, frame_start
    );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
//   clk, rst_n  clock, asynchronous active-low reset
//   inc         advance the counter this cycle
//   count       registered position, 0..TOTAL-1
//   wrap        count is at TOTAL-1 (the next increment returns to 0)
//   sync_act    the value count takes after this edge lies in [SYNC_START, SYNC_END)
//   vis         the value count takes after this edge is below VISIBLE
// sync_act/vis look one edge ahead so the parent can register them and have
// them line up with count in the same cycle.
module vga_axis_counter #(
    parameter int unsigned TOTAL      = 1040,
    parameter int unsigned SYNC_START = 856,
    parameter int unsigned SYNC_END   = 976,
    parameter int unsigned VISIBLE    = 800,
    parameter int unsigned W          = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync_act,
    output logic         vis
);

    logic [W-1:0] count_nxt;

    assign wrap = (count == W'(TOTAL - 1));

    // NOTE: count_nxt is assigned its hold value first, so a cycle with inc=0
    // leaves no path unassigned and no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (inc) begin
            count_nxt = wrap ? '0 : count + W'(1);
        end
    end

    // NOTE: state uses non-blocking assignment so every register samples the
    // pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    // One spare bit so SYNC_END may equal 2**W without truncating.
    assign sync_act = ({1'b0, count_nxt} >= (W+1)'(SYNC_START)) &&
                      ({1'b0, count_nxt} <  (W+1)'(SYNC_END));
    assign vis      = ({1'b0, count_nxt} <  (W+1)'(VISIBLE));

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster scan generator for all pixel-producing blocks.
//   clk    pixel-domain clock
//   rst_n  asynchronous active-low reset
//   vga    vga_timing_gen_if.master: en in; hcount, vcount, hsync, vsync,
//          blank, line_start, frame_start out (all registered)
// Build option VGA_PIXEL_ALIGN_EN: hsync/vsync/blank get one more enabled
// register stage and lag hcount/vcount by one enabled cycle. Without it they
// match the counters presented in the same cycle.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter bit          SYNC_POL  = SYNC_POL_DEF
) (
    input logic             clk,
    input logic             rst_n,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > H_TOTAL_MAX) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL exceeds 11-bit hcount range");
    end
    if (V_TOTAL > V_TOTAL_MAX) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL exceeds 10-bit vcount range");
    end

    logic h_wrap, h_sync_act, h_vis;
    logic v_wrap, v_sync_act, v_vis;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC),
        .VISIBLE    (H_VISIBLE),
        .W          (HCW)
    ) u_h (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (vga.en),
        .count    (vga.hcount),
        .wrap     (h_wrap),
        .sync_act (h_sync_act),
        .vis      (h_vis)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC),
        .VISIBLE    (V_VISIBLE),
        .W          (VCW)
    ) u_v (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (vga.en & h_wrap),
        .count    (vga.vcount),
        .wrap     (v_wrap),
        .sync_act (v_sync_act),
        .vis      (v_vis)
    );

    logic hsync_r, vsync_r, blank_r, line_start_r, frame_start_r;

    // Decodes come from the counters' next values, so these registers land on
    // the same edge as the counts they describe. With en high, hcount goes to 0
    // exactly when it is wrapping now, which gives the strobes directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            blank_r       <= 1'b0;
            line_start_r  <= 1'b1;
            frame_start_r <= 1'b1;
        end else if (vga.en) begin
            hsync_r       <= h_sync_act ? SYNC_POL : ~SYNC_POL;
            vsync_r       <= v_sync_act ? SYNC_POL : ~SYNC_POL;
            blank_r       <= ~(h_vis & v_vis);
            line_start_r  <= h_wrap;
            frame_start_r <= h_wrap & v_wrap;
        end
    end

    assign vga.line_start  = line_start_r;
    assign vga.frame_start = frame_start_r;

`ifdef VGA_PIXEL_ALIGN_EN
    logic hsync_a, vsync_a, blank_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_a <= ~SYNC_POL;
            vsync_a <= ~SYNC_POL;
            blank_a <= 1'b0;
        end else if (vga.en) begin
            hsync_a <= hsync_r;
            vsync_a <= vsync_r;
            blank_a <= blank_r;
        end
    end

    assign vga.hsync = hsync_a;
    assign vga.vsync = vsync_a;
    assign vga.blank = blank_a;
`else
    assign vga.hsync = hsync_r;
    assign vga.vsync = vsync_r;
    assign vga.blank = blank_r;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster scan that drives all pixel-producing blocks (board, paddles, ball).
- A horizontal counter runs every enabled clock and a vertical counter advances at each line wrap.
- Registered hcount/vcount, hsync/vsync, blank and frame/line strobes are decoded from these counters.
- Default timing: 800x600 @ 72 Hz with a 50 MHz pixel clock; total 1040 x 666.

Parameters:
- H_VISIBLE, 800, visible pixels per line
- H_FRONT, 56, horizontal front porch
- H_SYNC, 120, hsync pulse width
- H_BACK, 64, horizontal back porch
- V_VISIBLE, 600, visible lines per frame
- V_FRONT, 37, vertical front porch
- V_SYNC, 6, vsync pulse width in lines
- V_BACK, 23, vertical back porch
- SYNC_POL, 1, active level of hsync/vsync (1 = positive)

Ports:
- clk  in  1  pixel-domain clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  pixel enable; counters and outputs advance only when 1
- hcount  out  11  horizontal position, 0..H_TOTAL-1
- vcount  out  10  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level SYNC_POL when active
- vsync  out  1  vertical sync, level SYNC_POL when active
- blank  out  1  high outside the visible area
- line_start  out  1  one-cycle strobe when hcount==0
- frame_start  out  1  one-cycle strobe when hcount==0 and vcount==0

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* parameters (1040); V_TOTAL = sum of the four V_* parameters (666).
- Reset (rst_n low, asynchronous):
  - hcount=0, vcount=0, blank=0
  - hsync=vsync=~SYNC_POL
  - line_start=1, frame_start=1
- Reset mid-frame immediately returns all outputs to these values.
- First enabled cycle after rst_n rises advances hcount to 1.
- On each clk rising edge with en=1:
  - hcount increments; at H_TOTAL-1 it wraps to 0.
  - vcount increments only on the hcount wrap; at V_TOTAL-1 (on that wrap) it wraps to 0.
- With en=0, every output holds its value. Strobes also hold, so line_start stays high for as many cycles as en is low while hcount==0.
- All outputs are registered. Decode is computed from the next counter values, so every output is consistent with the hcount/vcount presented in the same cycle (zero relative latency):
  - hsync active iff H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC, i.e. 856..975.
  - vsync active iff V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC, i.e. 637..642. Asserted for whole lines, including hcount==0 of line 637.
  - blank = (hcount >= H_VISIBLE) or (vcount >= V_VISIBLE).
- Frame wrap: the transition (1039, 665) -> (0, 0) occurs in a single cycle, and frame_start rises in that same cycle.
- Width rules:
  - Compare widths are 11 bits for H and 10 bits for V.
  - Parameter sets must satisfy H_TOTAL <= 2048 and V_TOTAL <= 1024; elaboration fails with a static check otherwise.

Optional Feature:
- Macro: VGA_PIXEL_ALIGN_EN.
- With it defined:
  - hsync, vsync and blank pass through one extra register stage (also gated by en).
  - They lag hcount/vcount by one enabled cycle, aligning with downstream blocks that register pixel one cycle after sampling the counters.
  - Reset values of the delayed copies match the reset values above.
- Without it: zero relative latency, as specified in Behaviour.
- hcount, vcount and the strobes are identical in both builds.

Decomposition:
- Package vga_pkg:
  - default timing constants for 800x600@72
  - derived H_TOTAL/V_TOTAL functions
  - counter width localparams
- Sub-module vga_axis_counter (params TOTAL, SYNC_START, SYNC_END, VISIBLE):
  - inputs: clk, rst_n, inc
  - outputs: count, wrap, sync_act, vis
- vga_timing_gen instantiates vga_axis_counter twice. The H instance has inc=en; the V instance has inc=en & h.wrap.

Test Plan:
- Reset then en=1 for 1040 cycles:
  - hcount sequence 0..1039 then 0; vcount steps 0->1 exactly on the wrap.
  - line_start high only at hcount 0.
- One full line at vcount=0:
  - hsync high for exactly 120 cycles (hcount 856..975).
  - blank high for hcount 800..1039 (240 cycles).
- Full frame of 1040*666=692640 cycles:
  - vsync high on lines 637..642 only.
  - frame_start pulses once, at the start of the next frame.
- en toggled 1/0 alternately: all outputs advance every other cycle and a frame takes 1385280 cycles.
- Assert rst_n low at hcount=500, vcount=300, mid-cycle: outputs return to reset values without waiting for a clk edge.
- Build with VGA_PIXEL_ALIGN_EN: hsync first rises one enabled cycle after hcount==856; blank first rises when hcount==801.
